ram_dma_scheduler: RTL

- Sequences the shared single-port RAM between the FFT, FIR and IIR accelerators.
- Moves one frame per channel:
  - RAM source region -> to_<ch> FIFO (feed).
  - from_<ch> FIFO -> RAM destination region (drain).
- Owns addr, ram_read_enable, ram_write_enable and the tri-state drive of data_bus.
- Drives the per-channel enable, put_req and get_req signals used by top_level.

---
 rtl/ram_dma_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_dma_scheduler.sv
// ram_dma_scheduler: owns the shared single-port RAM and moves one frame per
// channel (fft=0, fir=1, iir=2). The feed path is RAM source region -> to_<ch>
// FIFO, and the drain path is from_<ch> FIFO -> RAM destination region. Only one
// 3-cycle transfer is in flight at a time: SEL, then RD+PUSH or POP+WR.
module ram_dma_scheduler #(
    parameter int          BLOCK_LEN   = 64,
    parameter logic [31:0] REGION_SIZE = 32'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  chan_en,
    input  logic        to_fft_full,
    input  logic        to_fir_full,
    input  logic        to_iir_full,
    input  logic        from_fft_empty,
    input  logic        from_fir_empty,
    input  logic        from_iir_empty,
    input  logic [31:0] fft_data_in,
    input  logic [31:0] fir_data_in,
    input  logic [31:0] iir_data_in,
    output logic [31:0] fft_data_out,
    output logic [31:0] fir_data_out,
    output logic [31:0] iir_data_out,
    output logic        fft_put_req,
    output logic        fir_put_req,
    output logic        iir_put_req,
    output logic        fft_get_req,
    output logic        fir_get_req,
    output logic        iir_get_req,
    output logic        fft_enable,
    output logic        fir_enable,
    output logic        iir_enable,
    output logic [31:0] addr,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    inout  wire  [31:0] data_bus,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, SEL, RD, PUSH, POP, WR, FIN} state_t;

    localparam logic [15:0] BLK = 16'(BLOCK_LEN);

    state_t      state_q, state_d;
    logic [2:0]  active_q, active_d;
    logic [15:0] src_cnt_q [3];
    logic [15:0] src_cnt_d [3];
    logic [15:0] dst_cnt_q [3];
    logic [15:0] dst_cnt_d [3];
    logic [31:0] word_q [3];
    logic [31:0] word_d [3];
    logic [1:0]  rr_q, rr_d;      // channel searched first in the next SEL
    logic [1:0]  ch_q, ch_d;      // channel owning the transfer in flight

    logic [2:0]  to_full, from_empty, drain_ok, feed_ok;
    logic [31:0] din [3];
    logic        grant, grant_drain, all_done;
    logic [1:0]  grant_ch;

    assign to_full    = {to_iir_full, to_fir_full, to_fft_full};
    assign from_empty = {from_iir_empty, from_fir_empty, from_fft_empty};
    assign din[0]     = fft_data_in;
    assign din[1]     = fir_data_in;
    assign din[2]     = iir_data_in;

    // Per-channel eligibility and round-robin winner, drain preferred over feed
    always_comb begin
        int idx;
        grant       = 1'b0;
        grant_drain = 1'b0;
        grant_ch    = rr_q;
        all_done    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drain_ok[k] = active_q[k] && (dst_cnt_q[k] < BLK) && !from_empty[k];
            feed_ok[k]  = active_q[k] && (src_cnt_q[k] < BLK) && !to_full[k];
            if (active_q[k] && ((src_cnt_q[k] != BLK) || (dst_cnt_q[k] != BLK)))
                all_done = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= 3) idx = idx - 3;
            if (!grant && (drain_ok[idx] || feed_ok[idx])) begin
                grant       = 1'b1;
                grant_ch    = 2'(idx);
                grant_drain = drain_ok[idx];
            end
        end
    end

    // Next-state logic for the sequencer, counters, pointer and read latches
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rr_d     = rr_q;
        ch_d     = ch_q;
        for (int k = 0; k < 3; k++) begin
            src_cnt_d[k] = src_cnt_q[k];
            dst_cnt_d[k] = dst_cnt_q[k];
            word_d[k]    = word_q[k];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    active_d = chan_en;
                    for (int k = 0; k < 3; k++) begin
                        src_cnt_d[k] = '0;
                        dst_cnt_d[k] = '0;
                    end
                    state_d = SEL;
                end
            end
            SEL: begin
                if (grant) begin
                    ch_d    = grant_ch;
                    rr_d    = (grant_ch == 2'd2) ? 2'd0 : grant_ch + 2'd1;
                    state_d = grant_drain ? POP : RD;
                end else if (all_done) begin
                    state_d = FIN;
                end
            end
            RD: begin
                word_d[ch_q] = data_bus;
                state_d      = PUSH;
            end
            PUSH: begin
                src_cnt_d[ch_q] = src_cnt_q[ch_q] + 16'd1;
                state_d         = SEL;
            end
            POP:  state_d = WR;
            WR: begin
                dst_cnt_d[ch_q] = dst_cnt_q[ch_q] + 16'd1;
                state_d         = SEL;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            active_q <= '0;
            rr_q     <= '0;
            ch_q     <= '0;
            for (int k = 0; k < 3; k++) begin
                src_cnt_q[k] <= '0;
                dst_cnt_q[k] <= '0;
                word_q[k]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            rr_q     <= rr_d;
            ch_q     <= ch_d;
            for (int k = 0; k < 3; k++) begin
                src_cnt_q[k] <= src_cnt_d[k];
                dst_cnt_q[k] <= dst_cnt_d[k];
                word_q[k]    <= word_d[k];
            end
        end
    end

    // Strobes and address decode straight from the registered state
    always_comb begin
        logic [31:0] base;
        base             = 32'(ch_q) * REGION_SIZE;
        ram_read_enable  = (state_q == RD);
        ram_write_enable = (state_q == WR);
        addr             = '0;
        if (state_q == RD) addr = base + 32'(src_cnt_q[ch_q]);
        if (state_q == WR) addr = base + (REGION_SIZE >> 1) + 32'(dst_cnt_q[ch_q]);
        fft_put_req = (state_q == PUSH) && (ch_q == 2'd0);
        fir_put_req = (state_q == PUSH) && (ch_q == 2'd1);
        iir_put_req = (state_q == PUSH) && (ch_q == 2'd2);
        fft_get_req = (state_q == POP) && (ch_q == 2'd0);
        fir_get_req = (state_q == POP) && (ch_q == 2'd1);
        iir_get_req = (state_q == POP) && (ch_q == 2'd2);
        fft_enable  = active_q[0] && (dst_cnt_q[0] != BLK);
        fir_enable  = active_q[1] && (dst_cnt_q[1] != BLK);
        iir_enable  = active_q[2] && (dst_cnt_q[2] != BLK);
        busy        = (state_q != IDLE);
        done        = (state_q == FIN);
    end

    assign fft_data_out = word_q[0];
    assign fir_data_out = word_q[1];
    assign iir_data_out = word_q[2];
    assign data_bus     = (state_q == WR) ? din[ch_q] : {32{1'bz}};

endmodule
